float_result_collector: RTL and testbench
=========================================

# float_result_collector

Result-side counterpart of the round-robin floating-point distributor: gathers results from N identical non-pipelined arithmetic workers, each of which may finish with its own latency, and re-emits them as one in-order stream with a valid/ready handshake. It sits between the worker array and the downstream consumer. Results leave in exactly the round-robin order in which the workers were issued, starting from worker 0, even when workers complete out of order.

## Interface
- FLEN, from the shared float package: floating-point word width.
- N, default 20: number of workers; must be at least 2.
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  N  one-cycle completion pulse; bit i belongs to worker i.
- in_res  input  N*FLEN  worker results; worker i occupies bits [i*FLEN +: FLEN].
- in_negative  input  N  worker i result-negative flag.
- in_err  input  N  worker i error flag.
- res_vld  output  1  output word valid.
- res_rdy  input  1  consumer accepts the word when res_vld and res_rdy are both high.
- res  output  FLEN  in-order result.
- res_negative  output  1  flag travelling with res.
- err  output  1  flag travelling with res.
- busy  output  1  at least one slot is full.
- overflow  output  1  sticky; worker completed while its slot was still occupied.
- occupancy  output  $clog2(N+1)  number of full slots.

## Operation
- Storage is one slot per worker: a full bit plus {res, negative, err}.
- When in_vld[i] is high, slot i captures the worker data and its full bit is set on the next edge.
- Read pointer rd_ptr counts 0..N-1 and wraps from N-1 to 0.
- The outputs are driven from slot[rd_ptr]: res_vld = full[rd_ptr], and the data comes from that slot.
- On a handshake, full[rd_ptr] is cleared and rd_ptr advances by one.
- A slot whose index is not rd_ptr is held until the pointer reaches it. There is no skipping.
- Same-cycle drain and refill of the same slot: the new data is captured and full stays 1. This is not an overflow.
- in_vld[i] while full[i] is set and slot i is not draining this cycle:
  - overflow is set and stays set until rst.
  - The old contents are kept and the new result is dropped.
- occupancy equals the popcount of the full bits; it is updated the same cycle the full bits change.
- res, res_negative and err hold stable while res_vld=1 and res_rdy=0.

## Timing
- Reset values:
  - res_vld=0, res='0, res_negative=0, err=0, busy=0, overflow=0, occupancy=0.
  - rd_ptr=0 and all full bits are cleared.
- Reset mid-operation discards all stored results.
- Without bypass, latency is 1 cycle: in_vld on edge k gives res_vld on the cycle after edge k, provided that slot is at rd_ptr.
- With res_rdy held high and workers completing in order, the block delivers one result per cycle.
- When res_rdy is low, slots fill independently. The block applies no backpressure to workers: the dispatcher must not reissue worker i before slot i drains, and overflow flags any violation.

## Configuration
- FLOAT_COLLECTOR_BYPASS_EN defined:
  - When full[rd_ptr]=0 and in_vld[rd_ptr]=1 in the same cycle, the worker data drives the outputs combinationally and res_vld=1 that cycle.
  - If res_rdy=1, the slot is not written and rd_ptr advances. Latency is 0.
  - If res_rdy=0, the data is captured normally.
- Undefined: all results pass through a slot and the minimum latency is 1 cycle.

## Test plan
- Reset, then N=4 and workers 0,1,2,3 pulse on consecutive cycles with values 1.0, 2.0, 3.0, 4.0, res_rdy=1 -> four consecutive res_vld beats 1.0, 2.0, 3.0, 4.0; occupancy returns to 0.
- Out of order: worker 2, then 1, then 0 complete -> no res_vld until worker 0 arrives, then beats in order 0, 1, 2; rd_ptr=3.
- Backpressure: res_rdy=0 for 5 cycles while workers 0 and 1 complete -> res holds worker 0 value stable, occupancy=2; releasing res_rdy drains both in order.
- Wrap: 2N results streamed -> order 0..N-1 then 0..N-1, with no gap at the wrap.
- Overflow: worker 0 completes twice with res_rdy=0 -> overflow=1 and the first value is kept; rst clears overflow, res_vld and occupancy.
- Bypass, macro on: slot 0 empty, in_vld[0] with res_rdy=1 -> res_vld in the same cycle and occupancy stays 0. Macro off: res_vld one cycle later.

Source files
------------

// File: rtl/float_result_collector.sv
// float_result_collector
//   Gathers results from N non-pipelined floating-point workers that were
//   issued round-robin starting at worker 0. It re-emits them in that same
//   order as a single valid/ready stream, even when workers finish out of order.
//
//   Each worker owns one slot: a full bit plus {res, negative, err}.
//   A read pointer walks the slots in order and never skips a slot.
//
//   Optional feature: define FLOAT_COLLECTOR_BYPASS_EN to allow a zero-latency
//   path. When the slot at the read pointer is empty and its worker completes
//   in the same cycle, the worker data is presented on the outputs directly.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   in_vld[N]        per-worker completion pulse
//   in_res[N*FLEN]   per-worker result, worker i at [i*FLEN +: FLEN]
//   in_negative[N]   per-worker result-negative flag
//   in_err[N]        per-worker error flag
//   res_vld/res_rdy  output handshake
//   res              in-order result word
//   res_negative     negative flag travelling with res
//   err              error flag travelling with res
//   busy             at least one slot is full
//   overflow         sticky: a worker completed into a still-occupied slot
//   occupancy        number of full slots
module float_result_collector #(
  parameter int N    = 20,
  parameter int FLEN = 32,
  localparam int PW  = (N > 1) ? $clog2(N) : 1,
  localparam int OW  = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_vld,
  input  logic [N*FLEN-1:0] in_res,
  input  logic [N-1:0]      in_negative,
  input  logic [N-1:0]      in_err,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [FLEN-1:0]   res,
  output logic              res_negative,
  output logic              err,
  output logic              busy,
  output logic              overflow,
  output logic [OW-1:0]     occupancy
);

  logic [FLEN-1:0] in_word  [N];
  logic [FLEN-1:0] slot_res [N];
  logic [N-1:0]    slot_neg;
  logic [N-1:0]    slot_err;
  logic [N-1:0]    full;
  logic [N-1:0]    full_nxt;
  logic [N-1:0]    wr_en;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   occ_nxt;
  logic            hs;
  logic            byp_take;
  logic            ovf_hit;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_word[i] = in_res[i*FLEN +: FLEN];
    end
  end

  // Output mux. Data always comes from the slot under the read pointer.
  // The slot is never overwritten while it is full and not draining.
  // That keeps res stable under backpressure.
  always_comb begin
    res_vld      = full[rd_ptr];
    res          = slot_res[rd_ptr];
    res_negative = slot_neg[rd_ptr];
    err          = slot_err[rd_ptr];
    byp_take     = 1'b0;
`ifdef FLOAT_COLLECTOR_BYPASS_EN
    if (!full[rd_ptr] && in_vld[rd_ptr]) begin
      res_vld      = 1'b1;
      res          = in_word[rd_ptr];
      res_negative = in_negative[rd_ptr];
      err          = in_err[rd_ptr];
      byp_take     = res_rdy;
    end
`endif
  end

  assign hs   = res_vld & res_rdy;
  assign busy = |full;

  // Slot update. A drain and a refill of the same slot in one cycle keeps the
  // slot full with the new data. A completion into an occupied, non-draining
  // slot is dropped and flagged as an overflow.
  always_comb begin
    full_nxt = full;
    wr_en    = '0;
    ovf_hit  = 1'b0;
    occ_nxt  = '0;
    for (int i = 0; i < N; i++) begin
      if (hs && (PW'(i) == rd_ptr)) begin
        full_nxt[i] = 1'b0;
      end
      if (in_vld[i] && !(byp_take && (PW'(i) == rd_ptr))) begin
        if (full[i] && !(hs && (PW'(i) == rd_ptr))) begin
          ovf_hit = 1'b1;
        end else begin
          wr_en[i]    = 1'b1;
          full_nxt[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      occ_nxt = occ_nxt + OW'(full_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      occupancy <= '0;
      slot_neg  <= '0;
      slot_err  <= '0;
      for (int i = 0; i < N; i++) begin
        slot_res[i] <= '0;
      end
    end else begin
      full      <= full_nxt;
      occupancy <= occ_nxt;
      if (ovf_hit) begin
        overflow <= 1'b1;
      end
      if (hs) begin
        rd_ptr <= (rd_ptr == PW'(N - 1)) ? '0 : rd_ptr + 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (wr_en[i]) begin
          slot_res[i] <= in_word[i];
          slot_neg[i] <= in_negative[i];
          slot_err[i] <= in_err[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_float_result_collector.sv
// Bench for float_result_collector with N=4.
// Reference model: each worker holds a pending result. Expected output is the
// pending result of worker (results consumed so far mod N).
module tb_float_result_collector;
  localparam int N    = 4;
  localparam int FLEN = 32;
  localparam int OW   = $clog2(N + 1);
`ifdef FLOAT_COLLECTOR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_vld;
  logic [N*FLEN-1:0] in_res;
  logic [N-1:0]      in_negative;
  logic [N-1:0]      in_err;
  logic              res_vld;
  logic              res_rdy;
  logic [FLEN-1:0]   res;
  logic              res_negative;
  logic              err;
  logic              busy;
  logic              overflow;
  logic [OW-1:0]     occupancy;

  float_result_collector #(.N(N), .FLEN(FLEN)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_res(in_res),
    .in_negative(in_negative), .in_err(in_err), .res_vld(res_vld),
    .res_rdy(res_rdy), .res(res), .res_negative(res_negative), .err(err),
    .busy(busy), .overflow(overflow), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  bit              m_pend [N];
  logic [FLEN-1:0] m_res  [N];
  bit              m_neg  [N];
  bit              m_err  [N];
  int              m_cnt;
  bit              m_ovf;
  int              n_take;
  bit              last_vld;

  // per-worker data driven with the next pulse
  logic [FLEN-1:0] drv_res [N];
  bit              drv_neg [N];
  bit              drv_err [N];

  task automatic model_clear();
    for (int w = 0; w < N; w++) begin
      m_pend[w] = 1'b0; m_res[w] = '0; m_neg[w] = 1'b0; m_err[w] = 1'b0;
    end
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_vld = '0; res_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_res_vld", res_vld, 0);
    check("rst_res", res, 0);
    check("rst_res_negative", res_negative, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_occupancy", occupancy, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive pulses m with res_rdy=rdy and check the outputs
  // before the edge. Then advance the model and check the state after the edge.
  task automatic step(input logic [N-1:0] m, input bit rdy);
    int hw;
    bit byp_now, ev, take;
    bit old_pend [N];
    int occ;
    @(negedge clk);
    res_rdy = rdy;
    in_vld  = m;
    for (int w = 0; w < N; w++) begin
      in_res[w*FLEN +: FLEN] = drv_res[w];
      in_negative[w] = drv_neg[w];
      in_err[w]      = drv_err[w];
    end
    #1;
    hw      = m_cnt % N;
    byp_now = BYP && !m_pend[hw] && m[hw];
    ev      = m_pend[hw] || byp_now;
    last_vld = res_vld;
    check("res_vld", res_vld, ev);
    if (ev) begin
      check("res", res, m_pend[hw] ? m_res[hw] : drv_res[hw]);
      check("res_negative", res_negative, m_pend[hw] ? m_neg[hw] : drv_neg[hw]);
      check("err", err, m_pend[hw] ? m_err[hw] : drv_err[hw]);
    end
    take = ev && rdy;
    @(posedge clk);
    old_pend = m_pend;
    if (take) m_pend[hw] = 1'b0;
    for (int w = 0; w < N; w++) begin
      if (m[w] && !(byp_now && take && w == hw)) begin
        if (old_pend[w] && !(take && w == hw)) begin
          m_ovf = 1'b1;
        end else begin
          m_pend[w] = 1'b1;
          m_res[w]  = drv_res[w];
          m_neg[w]  = drv_neg[w];
          m_err[w]  = drv_err[w];
        end
      end
    end
    if (take) begin
      m_cnt++;
      n_take++;
    end
    #1;
    occ = 0;
    for (int w = 0; w < N; w++) occ += int'(m_pend[w]);
    check("occupancy", occupancy, occ);
    check("busy", busy, occ != 0);
    check("overflow", overflow, m_ovf);
  endtask

  initial begin
    int n0;
    int hw_r;
    bit rdy_r;
    logic [N-1:0] m;
    rst = 1'b1; in_vld = '0; in_res = '0; in_negative = '0; in_err = '0; res_rdy = 1'b0;
    n_take = 0;
    for (int w = 0; w < N; w++) begin
      drv_res[w] = '0; drv_neg[w] = 1'b0; drv_err[w] = 1'b0;
    end
    model_clear();
    do_reset();

    // in order, one beat per cycle
    drv_res[0] = 32'h3f80_0000; drv_res[1] = 32'h4000_0000;
    drv_res[2] = 32'h4040_0000; drv_res[3] = 32'h4080_0000;
    drv_neg[2] = 1'b1; drv_err[3] = 1'b1;
    n0 = n_take;
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("inorder_beats", n_take - n0, 4);
    check("inorder_occ", occupancy, 0);

    // out of order completion: 2, 1, then 0
    do_reset();
    n0 = n_take;
    step(4'b0100, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    check("ooo_no_vld", n_take - n0, 0);
    step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("ooo_beats", n_take - n0, 3);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    check("ooo_slot3_next", n_take - n0, 4);

    // backpressure for five cycles
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check("bp_hold", res, 32'h3f80_0000);
    check("bp_occ", occupancy, 2);
    n0 = n_take;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("bp_drain", n_take - n0, 2);

    // wrap: 2N results streamed back to back
    do_reset();
    n0 = n_take;
    for (int k = 0; k < 2 * N; k++) begin
      drv_res[k % N] = 32'(k + 1);
      m = '0;
      m[k % N] = 1'b1;
      step(m, 1'b1);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("wrap_beats", n_take - n0, 2 * N);

    // overflow: worker 0 completes twice with the consumer stalled
    do_reset();
    drv_res[0] = 32'h1111_1111;
    step(4'b0001, 1'b0);
    drv_res[0] = 32'h2222_2222;
    step(4'b0001, 1'b0);
    check("ovf_flag", overflow, 1);
    check("ovf_keep", res, 32'h1111_1111);
    step(4'b0000, 1'b0);
    check("ovf_sticky", overflow, 1);
    do_reset();

    // latency of the first beat
    drv_res[0] = 32'h3f80_0000;
    step(4'b0001, 1'b1);
    check("lat_first_cycle", last_vld, BYP);
    check("lat_occ", occupancy, BYP ? 0 : 1);
    step(4'b0000, 1'b1);
    check("lat_second_cycle", last_vld, !BYP);

    // randomized traffic, including same-cycle drain and refill
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rdy_r = ($urandom_range(3) != 0);
      hw_r  = m_cnt % N;
      m     = '0;
      for (int w = 0; w < N; w++) begin
        drv_res[w] = $urandom;
        drv_neg[w] = 1'($urandom_range(1));
        drv_err[w] = 1'($urandom_range(1));
        if ($urandom_range(2) == 0 && (!m_pend[w] || (w == hw_r && rdy_r)))
          m[w] = 1'b1;
      end
      step(m, rdy_r);
    end
    step(4'b1111, 1'b0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
